// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Purpose  : Word-organised data memory for the MEM stage of the RISC-V core.
//             Word writes are synchronous and word reads are combinational.
//             Both are gated by their enables. Reset clears every location.
//  Ports    : clk         rising-edge clock
//             rst         asynchronous active-low reset (0 = clear array)
//             mem_read    read enable; read_data is 0 when low
//             mem_write   write enable, sampled on the rising clk edge
//             addr        byte address; word index = addr[$clog2(DEPTH)+1:2]
//             write_data  word stored when mem_write=1
//             read_data   word at addr when mem_read=1 and addr is in range
//  Revision : 1.0  initial release
// ============================================================================
module data_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    localparam int c_IDX_W = $clog2(DEPTH);

    // One extra bit so DEPTH*4 is representable even when it fills ADDR_W.
    localparam logic [ADDR_W:0] c_SPAN = (ADDR_W + 1)'(DEPTH * 4);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;

    // addr[1:0] is dropped, so an unaligned address hits its containing word.
    assign w_idx      = addr[c_IDX_W+1:2];
    assign w_in_range = ({1'b0, addr} < c_SPAN);

    // While rst is low the whole array is held at zero and writes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_write && w_in_range) begin
            r_mem[w_idx] <= write_data;
        end
    end

    // No bypass: a write in the same cycle becomes visible only after the edge.
    assign read_data = (mem_read && w_in_range) ? r_mem[w_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem
//  Purpose  : Directed self-checking bench for data_mem (DEPTH=256, 32-bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] c_END = ADDR_W'(DEPTH * 4);

    logic              clk;
    logic              rst;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    int n_cmp;
    int n_err;

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write across a single rising edge; inputs change on negedge.
    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        addr       = 32'h04;
        write_data = 32'hBADBAD00;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_read: got %h expected %h", read_data, 32'h0);
        end
        // A rising edge occurs while rst is low with mem_write high: must be blocked.
        #9;
        @(negedge clk);
        mem_write = 1'b0;
        rst       = 1'b1;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_blocks_write: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_write_read();
        write_word(32'h04, 32'hDEADBEEF);
        mem_read = 1'b1;
        addr     = 32'h04;
        #1;
        n_cmp++;
        if (read_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_read_04: got %h expected %h", read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_second_write();
        write_word(32'h08, 32'h12345678);
        mem_read = 1'b1;
        addr     = 32'h08;
        #1;
        n_cmp++;
        if (read_data !== 32'h12345678) begin
            n_err++;
            $display("FAIL write_read_08: got %h expected %h", read_data, 32'h12345678);
        end
        addr = 32'h04;
        #1;
        n_cmp++;
        if (read_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL no_alias_04: got %h expected %h", read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_unwritten();
        mem_read = 1'b1;
        addr     = 32'h0C;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL unwritten_0C: got %h expected %h", read_data, 32'h0);
        end
        mem_read = 1'b0;
        addr     = 32'h04;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL read_disabled: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_reset_clears();
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 32'h04;
        rst      = 1'b0;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async_04: got %h expected %h", read_data, 32'h0);
        end
        #9;
        rst  = 1'b1;
        addr = 32'h04;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cleared_04: got %h expected %h", read_data, 32'h0);
        end
        addr = 32'h08;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cleared_08: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_addr_edges();
        write_word(32'h07, 32'hCAFEF00D);
        mem_read = 1'b1;
        addr     = 32'h04;
        #1;
        n_cmp++;
        if (read_data !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL unaligned_write: got %h expected %h", read_data, 32'hCAFEF00D);
        end
        addr = 32'h05;
        #1;
        n_cmp++;
        if (read_data !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL unaligned_read: got %h expected %h", read_data, 32'hCAFEF00D);
        end
        // DEPTH*4 would alias word 0 if the range check were missing.
        write_word(c_END, 32'h0BADF00D);
        mem_read = 1'b1;
        addr     = c_END;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL oor_read: got %h expected %h", read_data, 32'h0);
        end
        addr = 32'h00;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL oor_write_dropped: got %h expected %h", read_data, 32'h0);
        end
        write_word(c_END - 32'd4, 32'hA5A55A5A);
        mem_read = 1'b1;
        addr     = c_END - 32'd4;
        #1;
        n_cmp++;
        if (read_data !== 32'hA5A55A5A) begin
            n_err++;
            $display("FAIL last_word: got %h expected %h", read_data, 32'hA5A55A5A);
        end
    endtask

    task automatic test_read_during_write();
        write_word(32'h20, 32'h11111111);
        @(negedge clk);
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        addr       = 32'h20;
        write_data = 32'h22222222;
        #1;
        n_cmp++;
        if (read_data !== 32'h11111111) begin
            n_err++;
            $display("FAIL rdw_before_edge: got %h expected %h", read_data, 32'h11111111);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        n_cmp++;
        if (read_data !== 32'h22222222) begin
            n_err++;
            $display("FAIL rdw_after_edge: got %h expected %h", read_data, 32'h22222222);
        end
    endtask

    task automatic test_write_no_read();
        @(negedge clk);
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        addr       = 32'h30;
        write_data = 32'h87654321;
        @(posedge clk);
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin
            n_err++;
            $display("FAIL write_no_read_out: got %h expected %h", read_data, 32'h0);
        end
        mem_write = 1'b0;
        mem_read  = 1'b1;
        #1;
        n_cmp++;
        if (read_data !== 32'h87654321) begin
            n_err++;
            $display("FAIL write_no_read_stored: got %h expected %h", read_data, 32'h87654321);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        write_data = '0;
        test_reset();
        test_write_read();
        test_second_write();
        test_unwritten();
        test_reset_clears();
        test_addr_edges();
        test_read_during_write();
        test_write_no_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
